// File: rtl/priority_encoder_4_to_2_db.sv
// ---------------------------------------------------------------------------
// priority_encoder_4_to_2_db
//
// Debounced 4-to-2 priority encoder. It takes four active-low request lines
// and reports the index of the highest-numbered active line. Each input goes
// through a two-flop synchroniser. A new candidate code must then stay
// unchanged for STABLE_CYCLES consecutive edges before it is committed to the
// outputs.
//
// State table:
//   state  | meaning
//   IDLE   | committed value is idle (V=0), waiting for a request
//   SETTLE | candidate differs from committed value, counting stable edges
//   HOLD   | committed value is a valid request (V=1), stable
//
// Parameters:
//   STABLE_CYCLES : consecutive edges a candidate must hold (>= 1)
//   CNT_W         : debounce counter width, 2**CNT_W > STABLE_CYCLES
//
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   En     : active-low enable; 1 forces the committed value to idle
//   D      : active-low request lines, D[3] has the highest priority
//   A, B   : committed index {A,B}
//   V      : committed request present
//   Strobe : one-cycle pulse when a new non-idle code is committed
// ---------------------------------------------------------------------------
module priority_encoder_4_to_2_db #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       En,
  input  logic [3:0] D,
  output logic       A,
  output logic       B,
  output logic       V,
  output logic       Strobe
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       sync_1;
  logic [3:0]       sync_2;

  logic [2:0]       cand;
  logic [1:0]       cand_code;
  logic             cand_any;

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       pend_q;
  logic [2:0]       pend_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       k_q;      // committed {V, A, B}
  logic [2:0]       k_d;
  logic             strobe_q;
  logic             strobe_d;
  logic             cnt_done;

  // Two-flop synchroniser. It resets to the idle pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 4'b1111;
      sync_2 <= 4'b1111;
    end else begin
      sync_1 <= D;
      sync_2 <= sync_1;
    end
  end

  // Candidate code: index of the highest-numbered zero bit.
  always_comb begin
    cand_code = 2'b00;
    if (!sync_2[3])      cand_code = 2'b11;
    else if (!sync_2[2]) cand_code = 2'b10;
    else if (!sync_2[1]) cand_code = 2'b01;
    else                 cand_code = 2'b00;
  end

  assign cand_any = ~&sync_2;
  assign cand     = {cand_any, cand_code};

  // The loading edge is count 1. This edge makes the count cnt_q + 1.
  // Using >= lets STABLE_CYCLES=1 still commit when leaving HOLD.
  assign cnt_done = (int'(cnt_q) + 1) >= STABLE_CYCLES;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= 3'b000;
      cnt_q    <= CNT_ZERO;
      k_q      <= 3'b000;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    strobe_d = 1'b0;

    if (En) begin
      state_d = IDLE;
      pend_d  = 3'b000;
      cnt_d   = CNT_ZERO;
      k_d     = 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (cand[2]) begin
            pend_d = cand;
            if (STABLE_CYCLES == 1) begin
              k_d      = cand;
              strobe_d = 1'b1;
              cnt_d    = CNT_ZERO;
              state_d  = HOLD;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = SETTLE;
            end
          end
        end

        SETTLE: begin
          if (cand == pend_q) begin
            if (cnt_done) begin
              k_d      = pend_q;
              strobe_d = pend_q[2];
              cnt_d    = CNT_ZERO;
              state_d  = pend_q[2] ? HOLD : IDLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (cand == k_q) begin
            // The input went back to the committed value before it settled.
            // Treat the change as a glitch and keep the outputs unchanged.
            cnt_d   = CNT_ZERO;
            state_d = k_q[2] ? HOLD : IDLE;
          end else begin
            pend_d = cand;
            cnt_d  = CNT_ONE;
          end
        end

        HOLD: begin
          if (cand != k_q) begin
            pend_d  = cand;
            cnt_d   = CNT_ONE;
            state_d = SETTLE;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  assign V      = k_q[2];
  assign A      = k_q[1];
  assign B      = k_q[0];
  assign Strobe = strobe_q;

endmodule

// File: tb/tb_priority_encoder_4_to_2_db.sv
module tb_priority_encoder_4_to_2_db;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       En;
  logic [3:0] D;
  logic       A, B, V, Strobe;

  int n_cmp = 0;
  int n_err = 0;
  int strobe_cnt = 0;

  // Reference model: synchroniser pipeline plus a run-length debouncer.
  logic [3:0] m_s1, m_s2;
  logic [2:0] m_k;       // {V, A, B}
  logic [2:0] m_last;
  int         m_run;
  logic       m_strobe;

  priority_encoder_4_to_2_db #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .En(En), .D(D),
    .A(A), .B(B), .V(V), .Strobe(Strobe)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: run did not complete, actual=running required=done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_cand(input logic [3:0] s);
    logic [2:0] c;
    c = 3'b000;
    for (int i = 0; i < 4; i++)
      if (s[i] == 1'b0) c = {1'b1, 2'(i)};
    return c;
  endfunction

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_k = 3'b000; m_last = 3'b000;
    m_run = 0; m_strobe = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] c;
    if (rst) begin
      model_reset();
      return;
    end
    c = ref_cand(m_s2);
    m_strobe = 1'b0;
    if (En) begin
      m_k = 3'b000;
      m_run = 0;
    end else if (c == m_k) begin
      m_run = 0;
    end else begin
      if (m_run > 0 && c == m_last) m_run++;
      else m_run = 1;
      m_last = c;
      if (m_run >= STABLE) begin
        m_k = c;
        m_strobe = c[2];
        m_run = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = D;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (Strobe === 1'b1) strobe_cnt++;
    check("model", {4'b0, A, B, V, Strobe}, {4'b0, m_k[1:0], m_k[2], m_strobe});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int s0;
    int hold;
    model_reset();
    rst = 1'b1; En = 1'b0; D = 4'hF;
    #2;
    check("reset_out", {4'b0, A, B, V, Strobe}, 8'h00);
    ticks(2);
    rst = 1'b0;
    ticks(4);

    // Assert reset in the middle of SETTLE. The outputs must clear at once.
    D = 4'b1011;
    ticks(3);
    #2 rst = 1'b1;
    #1;
    check("async_rst", {4'b0, A, B, V, Strobe}, 8'h00);
    model_reset();
    tick();
    rst = 1'b0;
    ticks(5);
    check("rst_recommit_early", {7'b0, V}, 8'h00);
    tick();
    check("rst_recommit", {4'b0, A, B, V, Strobe}, 8'b0000_1011);
    D = 4'hF;
    ticks(8);

    // Single request with exact latency.
    D = 4'b1101;
    ticks(5);
    check("single_early_v", {7'b0, V}, 8'h00);
    tick();
    check("single_commit", {4'b0, A, B, V, Strobe}, 8'b0000_0111);
    tick();
    check("single_strobe_off", {7'b0, Strobe}, 8'h00);
    D = 4'hF;
    ticks(8);

    // Priority between simultaneous requests.
    D = 4'b0110;
    ticks(6);
    check("prio_11", {5'b0, A, B, V}, 8'b0000_0111);
    s0 = strobe_cnt;
    D = 4'b1110;
    ticks(STABLE + 2);
    check("prio_00", {5'b0, A, B, V}, 8'b0000_0001);
    check("prio_one_strobe", 8'(strobe_cnt - s0), 8'd1);
    D = 4'hF;
    ticks(8);

    // A short glitch must not reach the outputs.
    s0 = strobe_cnt;
    D = 4'b0111;
    ticks(3);
    D = 4'hF;
    ticks(8);
    check("glitch_v", {7'b0, V}, 8'h00);
    check("glitch_strobe", 8'(strobe_cnt - s0), 8'd0);

    // Release from code 10, then a 2-cycle dropout that must be ignored.
    D = 4'b1011;
    ticks(8);
    check("hold_10", {5'b0, A, B, V}, 8'b0000_0101);
    s0 = strobe_cnt;
    D = 4'hF;
    ticks(5);
    check("release_early", {7'b0, V}, 8'h01);
    tick();
    check("release", {4'b0, A, B, V, Strobe}, 8'h00);
    check("release_nostrobe", 8'(strobe_cnt - s0), 8'd0);
    D = 4'b1011;
    ticks(8);
    D = 4'hF;
    ticks(2);
    D = 4'b1011;
    ticks(8);
    check("dropout_v", {5'b0, A, B, V}, 8'b0000_0101);

    // Disable while in HOLD, then re-enable with the request still held.
    En = 1'b1;
    tick();
    check("disable", {4'b0, A, B, V, Strobe}, 8'h00);
    ticks(2);
    En = 1'b0;
    ticks(3);
    check("reen_early", {7'b0, V}, 8'h00);
    tick();
    check("reen_commit", {4'b0, A, B, V, Strobe}, 8'b0000_1011);

    // Random stimulus against the model.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) D = 4'hF;
      else D = 4'($urandom_range(0, 15));
      En = ($urandom_range(0, 19) == 0);
      hold = $urandom_range(1, 7);
      ticks(hold);
    end
    En = 1'b0;
    ticks(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
